// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding and LFSR constants for the reaction game
// Purpose: state enum (also decoded by the display mux), LFSR seed and Galois tap mask.
// Ports: none (package).
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_DELAY      = 3'd2,
    ST_ARMED      = 3'd3,
    ST_RESULT     = 3'd4,
    ST_MATCH_OVER = 3'd5
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
// Purpose: pseudo-random source for the round delay; steps every clk, never reaches 0.
// Ports: clk - clock; rst - async active-low reset (loads seed); value - current LFSR state.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/reaction_match_ctrl.sv
// rtl/reaction_match_ctrl.sv - N-player reaction game round and match controller
// Purpose: countdown, random delay, timed reaction window, jump-start/tie handling,
//          per-player saturating scores and match end at WIN_SCORE. All outputs registered.
// Ports: clk, rst (async active-low), tick_1khz (1 kHz enable), start (one-clk pulse),
//        btn (debounced levels) -> state, countdown_val, go, reaction_ms, winner,
//        jump_start, scores (packed, player i at [i*SCORE_W +: SCORE_W]), round_over, match_over.
module reaction_match_ctrl
  import reaction_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 3,
  parameter int COUNT_SEC       = 3,
  parameter int TICK_PER_SEC    = 1000,
  parameter int DELAY_MIN_MS    = 1000,
  parameter int DELAY_SPAN_LOG2 = 11,
  parameter int TIMEOUT_MS      = 2000,
  parameter int MS_W            = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick_1khz,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         btn,
  output logic [2:0]                     state,
  output logic [3:0]                     countdown_val,
  output logic                           go,
  output logic [MS_W-1:0]                reaction_ms,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic [NUM_PLAYERS-1:0]         jump_start,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           round_over,
  output logic                           match_over
);

  localparam int TW = $clog2(TICK_PER_SEC) + 1;
  localparam int DW = $clog2(DELAY_MIN_MS + (1 << DELAY_SPAN_LOG2)) + 1;
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0] SCORE_ONE = (SCORE_W+1)'(1);

  state_e                   state_q, state_d;
  logic [3:0]               cd_q, cd_d;
  logic [TW-1:0]            tcnt_q, tcnt_d;
  logic [DW-1:0]            dly_q, dly_d;
  logic [MS_W-1:0]          ms_q, ms_d, ms_inc;
  logic                     go_q, go_d;
  logic [NUM_PLAYERS-1:0]   winner_q, winner_d, jump_q, jump_d;
  logic                     round_over_q, round_over_d, match_over_q, match_over_d;
  logic [NUM_PLAYERS-1:0]   btn_q, press, at_win;
  logic                     press_one;
  logic                     begin_round, inc_evt, dec_evt, clr_evt;
  logic [SCORE_W-1:0]       score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]       score_d [NUM_PLAYERS];
  logic [15:0]              lfsr_value;
  logic                     unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign unused_lfsr_bits = ^lfsr_value[15:DELAY_SPAN_LOG2];

  // Only rising edges count, so a button held from an earlier phase can never score.
  assign press     = btn & ~btn_q;
  assign press_one = (press != '0) && ((press & (press - NUM_PLAYERS'(1))) == '0);
  assign ms_inc    = ms_q + MS_W'(1);

  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    tcnt_d       = tcnt_q;
    dly_d        = dly_q;
    ms_d         = ms_q;
    go_d         = go_q;
    winner_d     = winner_q;
    jump_d       = jump_q;
    round_over_d = 1'b0;
    match_over_d = match_over_q;
    begin_round  = 1'b0;
    inc_evt      = 1'b0;
    dec_evt      = 1'b0;
    clr_evt      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin_round = start;
      ST_COUNTDOWN, ST_DELAY: begin
        // An early press beats any countdown/delay step in the same clk.
        if (|press) begin
          state_d      = ST_RESULT;
          jump_d       = press;
          winner_d     = '0;
          dec_evt      = 1'b1;
          round_over_d = 1'b1;
        end else if (tick_1khz) begin
          if (state_q == ST_COUNTDOWN) begin
            if (tcnt_q == TW'(TICK_PER_SEC - 1)) begin
              tcnt_d = '0;
              cd_d   = cd_q - 4'd1;
              if (cd_q == 4'd1) begin
                state_d = ST_DELAY;
                dly_d   = DW'(DELAY_MIN_MS) + DW'(lfsr_value[DELAY_SPAN_LOG2-1:0]);
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end else if (dly_q == DW'(1)) begin
            state_d = ST_ARMED;
            go_d    = 1'b1;
            ms_d    = '0;
          end else begin
            dly_d = dly_q - DW'(1);
          end
        end
      end
      ST_ARMED: begin
        if (tick_1khz) ms_d = ms_inc;
        // A press in the timeout clk still wins the round.
        if (|press) begin
          state_d      = ST_RESULT;
          go_d         = 1'b0;
          winner_d     = press;
          inc_evt      = press_one;
          round_over_d = 1'b1;
        end else if (tick_1khz && (ms_inc == MS_W'(TIMEOUT_MS))) begin
          state_d      = ST_RESULT;
          go_d         = 1'b0;
          winner_d     = '0;
          round_over_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (|at_win) begin
          state_d      = ST_MATCH_OVER;
          match_over_d = 1'b1;
        end else begin
          begin_round = start;
        end
      end
      ST_MATCH_OVER: begin
        if (start) begin
          begin_round  = 1'b1;
          clr_evt      = 1'b1;
          match_over_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (begin_round) begin
      state_d  = ST_COUNTDOWN;
      cd_d     = 4'(COUNT_SEC);
      tcnt_d   = '0;
      ms_d     = '0;
      winner_d = '0;
      jump_d   = '0;
      go_d     = 1'b0;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [SCORE_W:0]   cur, up;
    logic [SCORE_W-1:0] up_sat, down_sat;
    assign cur      = {1'b0, score_q[p]};
    assign up       = cur + SCORE_ONE;
    assign up_sat   = (up > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : up[SCORE_W-1:0];
    assign down_sat = (cur == '0) ? '0 : score_q[p] - SCORE_W'(1);
    assign score_d[p] = clr_evt               ? '0       :
                        (inc_evt && press[p]) ? up_sat   :
                        (dec_evt && press[p]) ? down_sat : score_q[p];
    assign at_win[p] = (score_q[p] == SCORE_W'(WIN_SCORE));
    assign scores[p*SCORE_W +: SCORE_W] = score_q[p];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cd_q         <= '0;
      tcnt_q       <= '0;
      dly_q        <= '0;
      ms_q         <= '0;
      go_q         <= 1'b0;
      winner_q     <= '0;
      jump_q       <= '0;
      round_over_q <= 1'b0;
      match_over_q <= 1'b0;
      btn_q        <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      tcnt_q       <= tcnt_d;
      dly_q        <= dly_d;
      ms_q         <= ms_d;
      go_q         <= go_d;
      winner_q     <= winner_d;
      jump_q       <= jump_d;
      round_over_q <= round_over_d;
      match_over_q <= match_over_d;
      btn_q        <= btn;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= score_d[p];
    end
  end

  assign state         = state_q;
  assign countdown_val = cd_q;
  assign go            = go_q;
  assign reaction_ms   = ms_q;
  assign winner        = winner_q;
  assign jump_start    = jump_q;
  assign round_over    = round_over_q;
  assign match_over    = match_over_q;

endmodule
